// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port unified instruction/data bus between the
//   instruction-fetch path and the MEM-stage load/store path. Only one bus
//   transaction is outstanding at a time. MEM wins over IF because it belongs
//   to the older instruction. Per-requester stall requests are combinational
//   functions of the pending conditions. They do not depend on stall_i.
//
//   Optional feature macro: UNIFIED_MEM_ARB_TIMEOUT_EN
//     defined   : a BUSY state gives up after MAX_WAIT cycles without ack.
//                 The returned data is 0 and bus_err_o is set sticky.
//     undefined : a BUSY state waits for ack forever. bus_err_o is tied 0.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   stall_i[5:0]           pipeline stall vector, bit 4 = MEM stage held
//   flush_i                pipeline flush, drops any in-flight IF result
//   if_ce_i, if_addr_i     fetch request
//   if_inst_o              last fetched instruction
//   if_stallreq_o          fetch not yet satisfied (combinational)
//   mem_ce_i/we_i/sel_i/addr_i/data_i   MEM-stage access request
//   mem_data_o             last load data
//   mem_stallreq_o         data access not yet complete (combinational)
//   bus_req_o/we_o/sel_o/addr_o/wdata_o registered bus request
//   bus_rdata_i, bus_ack_i bus response
//   bus_err_o              sticky timeout flag
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
  ,
  parameter int unsigned MAX_WAIT = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              if_stallreq_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i,
  output logic              bus_err_o
);

  localparam int unsigned SEL_W         = 4;
  localparam int unsigned MEM_STAGE_BIT = 4;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IF_BUSY  = 2'd1,
    S_MEM_BUSY = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic              bus_req_d;
  logic              bus_we_d;
  logic [SEL_W-1:0]  bus_sel_d;
  logic [ADDR_W-1:0] bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_d;
  logic [DATA_W-1:0] if_inst_d;
  logic [DATA_W-1:0] mem_data_d;
  logic [ADDR_W-1:0] if_addr_q, if_addr_d;
  logic              if_valid_q, if_valid_d;
  logic              mem_done_q, mem_done_d;
  logic              flush_seen_q, flush_seen_d;

  logic              if_pend;
  logic              mem_pend;
  logic              txn_timeout;
  logic              txn_end;

  // Only the MEM-stage hold bit matters here
  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

  // Pending conditions drive the stall requests directly
  assign if_pend        = if_ce_i & ~(if_valid_q & (if_addr_q == if_addr_i));
  assign mem_pend       = mem_ce_i & ~mem_done_q;
  assign if_stallreq_o  = if_pend;
  assign mem_stallreq_o = mem_pend;

  assign txn_end = bus_ack_i | txn_timeout;

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
  // Counter only needs to reach MAX_WAIT-1 before the abandon decision
  localparam int unsigned WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  // Abandon on the MAX_WAIT-th consecutive cycle without ack
  assign txn_timeout = (state_q != S_IDLE) & ~bus_ack_i &
                       (wait_cnt_q == WAIT_W'(MAX_WAIT - 1));

  // Cleared whenever idle, so every BUSY entry starts from zero
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q == S_IDLE) || txn_end) begin
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // Wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      bus_err_o  <= bus_err_o | txn_timeout;
    end
  end
`else
  assign txn_timeout = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // Next-state, bus request and result capture
  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_o;
    bus_we_d     = bus_we_o;
    bus_sel_d    = bus_sel_o;
    bus_addr_d   = bus_addr_o;
    bus_wdata_d  = bus_wdata_o;
    if_inst_d    = if_inst_o;
    if_addr_d    = if_addr_q;
    if_valid_d   = if_valid_q & ~flush_i;
    flush_seen_d = flush_seen_q | flush_i;
    mem_data_d   = mem_data_o;
    // mem_done drops once the MEM-stage instruction advances
    mem_done_d   = mem_done_q & stall_i[MEM_STAGE_BIT];

    unique case (state_q)
      S_IDLE: begin
        flush_seen_d = 1'b0;
        if (mem_pend) begin
          state_d     = S_MEM_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_data_i;
        end else if (if_pend) begin
          state_d      = S_IF_BUSY;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_sel_d    = {SEL_W{1'b1}};
          bus_addr_d   = if_addr_i;
          bus_wdata_d  = '0;
          // A flush in the launch cycle means this address is already stale
          flush_seen_d = flush_i;
        end
      end

      S_IF_BUSY: begin
        if (txn_end) begin
          state_d      = S_IDLE;
          bus_req_d    = 1'b0;
          flush_seen_d = 1'b0;
          if (flush_seen_q || flush_i) begin
            if_valid_d = 1'b0;
          end else begin
            if_inst_d  = txn_timeout ? '0 : bus_rdata_i;
            if_addr_d  = bus_addr_o;
            if_valid_d = 1'b1;
          end
        end
      end

      S_MEM_BUSY: begin
        if (txn_end) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          mem_done_d = 1'b1;
          if (!bus_we_o) begin
            mem_data_d = txn_timeout ? '0 : bus_rdata_i;
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_sel_o    <= '0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      if_inst_o    <= '0;
      mem_data_o   <= '0;
      if_addr_q    <= '0;
      if_valid_q   <= 1'b0;
      mem_done_q   <= 1'b0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_o    <= bus_req_d;
      bus_we_o     <= bus_we_d;
      bus_sel_o    <= bus_sel_d;
      bus_addr_o   <= bus_addr_d;
      bus_wdata_o  <= bus_wdata_d;
      if_inst_o    <= if_inst_d;
      mem_data_o   <= mem_data_d;
      if_addr_q    <= if_addr_d;
      if_valid_q   <= if_valid_d;
      mem_done_q   <= mem_done_d;
      flush_seen_q <= flush_seen_d;
    end
  end

endmodule
